// File: rtl/spi_reg_slave_if.sv
// Pin-side and register-file-side signals of spi_reg_slave, grouped for port connection.
interface spi_reg_slave_if #(
    parameter int unsigned DATA_W = 32
);
    logic              spi_sclk;
    logic              spi_csn;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              wr_en;
    logic [6:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [6:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  spi_sclk, spi_csn, spi_mosi, rd_data,
        output spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data,
               rd_req, rd_addr, frame_err, busy
    );

    modport master (
        output spi_sclk, spi_csn, spi_mosi, rd_data,
        input  spi_miso, spi_miso_oe, wr_en, wr_addr, wr_data,
               rd_req, rd_addr, frame_err, busy
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access slave: oversampled pins, 8-bit header + DATA_W data frames,
// single-cycle write strobes and read requests, read data shifted back on MISO.
module spi_reg_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 32
) (
    input  logic           aclk,
    input  logic           aresetn,
    spi_reg_slave_if.slave bus
);
    localparam int unsigned      FRAME_BITS   = DATA_W + 8;
    localparam int unsigned      CNT_W        = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] HDR_LAST     = CNT_W'(7);
    localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_END    = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] TX_SHIFT_MIN = CNT_W'(9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_RDATA,
        S_DONE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_d1_q;
    logic                   csn_d1_q;
    logic                   valid_q;
    logic                   arm_q;
    logic                   sclk_s;
    logic                   csn_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;
    logic                   cs_fall;
    logic                   cs_rise;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [6:0]        addr_q, addr_d;
    logic              rd_ld_q;
    logic              wr_en_q, wr_en_d;
    logic [6:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_req_q, rd_req_d;
    logic [6:0]        rd_addr_q, rd_addr_d;
    logic              frame_err_q, frame_err_d;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s   = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d1_q;
    assign fall    = ~sclk_s & sclk_d1_q;
    // The CSN chain resets to 1; arm_q blocks the false fall seen when the pin is still
    // low after reset, so a frame only starts once CSN has really been high.
    assign cs_fall = arm_q & ~csn_s & csn_d1_q;
    assign cs_rise = csn_s & ~csn_d1_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_d1_q   <= 1'b0;
            csn_d1_q    <= 1'b1;
            valid_q     <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], bus.spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_d1_q   <= sclk_s;
            csn_d1_q    <= csn_s;
            valid_q     <= 1'b1;
            arm_q       <= arm_q | (valid_q & csn_sync_q[0]);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            addr_q      <= '0;
            rd_ld_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            addr_q      <= addr_d;
            rd_ld_q     <= rd_req_q;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;

        if (rise && (state_q != S_IDLE) && (bitcnt_q != FRAME_END)) begin
            bitcnt_d = bitcnt_q + 1'b1;
        end

        unique case (state_q)
            S_HDR: begin
                if (rise) begin
                    rx_sr_d = {rx_sr_q[DATA_W-3:0], mosi_s};
                    if (bitcnt_q == HDR_LAST) begin
                        addr_d = {rx_sr_q[5:0], mosi_s};
                        if (rx_sr_q[6]) begin
                            rd_req_d  = 1'b1;
                            rd_addr_d = {rx_sr_q[5:0], mosi_s};
                            state_d   = S_RDATA;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rise) begin
                    rx_sr_d = {rx_sr_q[DATA_W-3:0], mosi_s};
                    if (bitcnt_q == FRAME_LAST) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = {rx_sr_q, mosi_s};
                        state_d   = S_DONE;
                    end
                end
            end
            S_RDATA: begin
                // Bit DATA_W-1 stays on MISO through fall 8; shifting starts at fall 9.
                if (rd_ld_q) begin
                    tx_sr_d = bus.rd_data;
                end else if (fall && (bitcnt_q >= TX_SHIFT_MIN)) begin
                    tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                end
                if (rise && (bitcnt_q == FRAME_LAST)) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        // CSN edges act on the state reached after this cycle's SCLK rise.
        if (cs_fall) begin
            frame_err_d = (state_q != S_IDLE);
            state_d     = S_HDR;
            bitcnt_d    = '0;
            rx_sr_d     = '0;
            tx_sr_d     = '0;
        end else if (cs_rise) begin
            if ((state_d == S_HDR) || (state_d == S_WDATA) || (state_d == S_RDATA)) begin
                frame_err_d = 1'b1;
            end
            state_d = S_IDLE;
        end
    end

    assign bus.spi_miso    = (state_q == S_RDATA) & tx_sr_q[DATA_W-1];
    assign bus.spi_miso_oe = ~csn_s;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_req      = rd_req_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: an SPI master drives frames, a reference of the frame rules
// predicts strobes, addresses, data and abort pulses.
module tb_spi_reg_slave;
    logic aclk;
    logic aresetn;

    int n_checks = 0;
    int n_bad    = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    int n_err    = 0;
    int n_both   = 0;

    logic [31:0] rd_val;

    spi_reg_slave_if #(.DATA_W(32)) bus ();

    spi_reg_slave #(
        .SYNC_STAGES(2),
        .DATA_W     (32)
    ) u_dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts strobes and remembers the last address/data seen with them.
    logic [6:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [6:0]  last_rd_addr;
    always @(negedge aclk) begin
        if (bus.wr_en === 1'b1) begin
            n_wr++;
            last_wr_addr = bus.wr_addr;
            last_wr_data = bus.wr_data;
        end
        if (bus.rd_req === 1'b1) begin
            n_rd++;
            last_rd_addr = bus.rd_addr;
        end
        if (bus.frame_err === 1'b1) n_err++;
        if (bus.wr_en === 1'b1 && bus.rd_req === 1'b1) n_both++;
    end

    // Register file: rd_data is valid only in the cycle after rd_req, random otherwise.
    initial begin
        bus.rd_data = '0;
        forever begin
            @(negedge aclk);
            if (bus.rd_req === 1'b1) begin
                @(posedge aclk);
                #1 bus.rd_data = rd_val;
                @(posedge aclk);
                #1 bus.rd_data = $urandom;
            end
        end
    end

    task automatic spi_frame(input logic [7:0] hdr, input logic [31:0] data,
                             input int unsigned n_rises, input int unsigned half,
                             input int unsigned gap, input bit cs_with_last,
                             output logic [31:0] miso_word);
        logic [39:0] frame;
        frame     = {hdr, data};
        miso_word = '0;
        @(posedge aclk);
        #1 bus.spi_csn = 1'b0;
        repeat (half) @(posedge aclk);
        for (int unsigned i = 0; i < n_rises; i++) begin
            #1 bus.spi_mosi = (i < 40) ? frame[39 - i] : 1'($urandom);
            repeat (half) @(posedge aclk);
            #1 bus.spi_sclk = 1'b1;
            if (cs_with_last && (i == n_rises - 1)) bus.spi_csn = 1'b1;
            if (i >= 8 && i < 40) miso_word = {miso_word[30:0], bus.spi_miso};
            repeat (half) @(posedge aclk);
            #1 bus.spi_sclk = 1'b0;
        end
        if (!cs_with_last) begin
            repeat (half) @(posedge aclk);
            #1 bus.spi_csn = 1'b1;
        end
        repeat (gap) @(posedge aclk);
        #1;
    endtask

    // Reference: outcome of one frame follows directly from header, rise count and CSN timing.
    task automatic run_frame(input logic [7:0] hdr, input logic [31:0] data, input logic [31:0] rdv,
                             input int unsigned n_rises, input int unsigned half,
                             input int unsigned gap, input bit cs_with_last);
        int          wr0, rd0, err0;
        logic [31:0] mw;
        bit          rnw, full;
        rnw    = hdr[7];
        full   = (n_rises >= 40);
        rd_val = rdv;
        wr0    = n_wr;
        rd0    = n_rd;
        err0   = n_err;
        spi_frame(hdr, data, n_rises, half, gap, cs_with_last, mw);
        check_eq("wr_count", n_wr - wr0, (!rnw && full) ? 1 : 0);
        check_eq("rd_count", n_rd - rd0, (rnw && n_rises >= 8) ? 1 : 0);
        check_eq("err_count", n_err - err0, full ? 0 : 1);
        if (!rnw && full) begin
            check_eq("wr_addr", {25'd0, last_wr_addr}, {25'd0, hdr[6:0]});
            check_eq("wr_data", last_wr_data, data);
        end
        if (rnw && n_rises >= 8) check_eq("rd_addr", {25'd0, last_rd_addr}, {25'd0, hdr[6:0]});
        if (rnw && full) check_eq("miso_word", mw, rdv);
        check_eq("busy_after", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_miso"},    {31'd0, bus.spi_miso},    32'd0);
        check_eq({pfx, "_oe"},      {31'd0, bus.spi_miso_oe}, 32'd0);
        check_eq({pfx, "_wr_en"},   {31'd0, bus.wr_en},       32'd0);
        check_eq({pfx, "_wr_addr"}, {25'd0, bus.wr_addr},     32'd0);
        check_eq({pfx, "_wr_data"}, bus.wr_data,              32'd0);
        check_eq({pfx, "_rd_req"},  {31'd0, bus.rd_req},      32'd0);
        check_eq({pfx, "_rd_addr"}, {25'd0, bus.rd_addr},     32'd0);
        check_eq({pfx, "_ferr"},    {31'd0, bus.frame_err},   32'd0);
        check_eq({pfx, "_busy"},    {31'd0, bus.busy},        32'd0);
    endtask

    initial begin
        logic [31:0]  mw;
        int           wr0, rd0, err0;
        int unsigned  sel, n, half, gap;
        bit           csl;

        aresetn      = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        rd_val       = '0;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        check_all_zero("reset");
        #1 aresetn = 1'b1;
        repeat (5) @(posedge aclk);

        run_frame(8'h01, 32'h0000_0003, 32'h0, 40, 10, 6, 1'b0);
        run_frame(8'h88, 32'h0, 32'hDEAD_BEEF, 40, 10, 6, 1'b0);
        run_frame(8'h02, 32'hFFFF_0000, 32'h0, 20, 10, 6, 1'b0);
        run_frame(8'h02, 32'h1234_5678, 32'h0, 40, 10, 6, 1'b0);
        run_frame(8'h7F, 32'hA5A5_A5A5, 32'h0, 48, 10, 6, 1'b0);

        // Reset during the data phase of a read.
        wr0 = n_wr;
        rd0 = n_rd;
        err0 = n_err;
        rd_val = 32'hCAFE_F00D;
        fork
            spi_frame(8'h93, 32'h0, 40, 10, 6, 1'b0, mw);
            begin
                repeat (410) @(posedge aclk);
                #1 aresetn = 1'b0;
                @(posedge aclk);
                @(negedge aclk);
                check_all_zero("midrst");
                repeat (2) @(posedge aclk);
                #1 aresetn = 1'b1;
            end
        join
        check_eq("midrst_err_count", n_err - err0, 0);
        check_eq("midrst_wr_count", n_wr - wr0, 0);
        check_eq("midrst_rd_count", n_rd - rd0, 1);
        check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
        run_frame(8'h05, 32'h0000_0001, 32'h0, 40, 10, 6, 1'b0);

        run_frame(8'h01, 32'h0000_0001, 32'h0, 40, 4, 4, 1'b0);
        run_frame(8'h81, 32'h0, 32'h0000_FFFF, 40, 4, 4, 1'b0);

        // CSN rises together with rise 40: write still completes, no abort.
        run_frame(8'h33, 32'h0BAD_F00D, 32'h0, 40, 6, 6, 1'b1);
        run_frame(8'hC4, 32'h0, 32'h8000_0001, 40, 6, 6, 1'b1);
        run_frame(8'hA0, 32'h0, 32'h1357_9BDF, 8, 5, 5, 1'b0);

        for (int k = 0; k < 12; k++) begin
            sel  = $urandom_range(0, 9);
            if (sel < 6)      n = 40;
            else if (sel < 8) n = $urandom_range(0, 39);
            else              n = $urandom_range(41, 48);
            half = $urandom_range(4, 8);
            gap  = $urandom_range(4, 8);
            csl  = (n == 40) && ($urandom_range(0, 3) == 0);
            run_frame(8'($urandom), $urandom, $urandom, n, half, gap, csl);
        end

        check_eq("wr_rd_same_cycle", n_both, 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
